// File: rtl/packer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : packer_pkg
// Description : Shared types and constants for the FIFO word packer.
//               - state_t   : packer FSM states (FILL collects, HOLD presents)
//               - nb_to_iw  : maps bytes-per-word to lane index width
// Revision    : 1.0 - initial release
// ============================================================================
package packer_pkg;

  typedef enum logic [0:0] {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;

  // Lane index width for each legal bytes-per-word value.
  function automatic int nb_to_iw(input int nb);
    case (nb)
      2:       return 1;
      4:       return 2;
      8:       return 3;
      default: return $clog2(nb);
    endcase
  endfunction

  localparam int NB_DEFAULT = 4;
  localparam int IW_DEFAULT = nb_to_iw(NB_DEFAULT);

endpackage
`default_nettype wire

// File: rtl/fifo_word_packer.sv
`default_nettype none
// ============================================================================
// Module      : fifo_word_packer
// Description : Pops bytes from a show-ahead sync FIFO and packs NB of them
//               into a little-endian word with a valid/ready output. A flush
//               pulse emits a partial word (out_last=1) once the FIFO drains.
// Ports       : clk, reset_n (sync, active-low)
//               fifo_empty, fifo_rd_data -> upstream FIFO head
//               fifo_rd_en               -> pop request (combinational)
//               flush                    -> request to emit partial word
//               out_valid/out_ready      -> word handshake
//               out_data/out_be/out_last -> packed word, lane enables, flush tag
//               lane_cnt                 -> bytes currently collected (0..NB)
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_word_packer
  import packer_pkg::*;
#(
  parameter int WD = 8,
  parameter int NB = 4,
  parameter int IW = nb_to_iw(NB)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             fifo_empty,
  input  logic [WD-1:0]    fifo_rd_data,
  output logic             fifo_rd_en,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [NB*WD-1:0] out_data,
  output logic [NB-1:0]    out_be,
  output logic             out_last,
  output logic [IW:0]      lane_cnt
);

  localparam logic [IW:0] c_NB_CNT    = (IW+1)'(NB);
  localparam logic [IW:0] c_LAST_LANE = (IW+1)'(NB - 1);
  localparam logic [IW:0] c_ONE       = (IW+1)'(1);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [IW:0]        r_lane_cnt;
  logic [NB*WD-1:0]   r_data;
  logic [NB-1:0]      r_be;
  logic               r_last;
  logic               r_flush_pend;

  logic               w_pop;
  logic               w_flush_emit;
  logic               w_flush_drop;
  logic               w_release;

  // Next-state and per-cycle actions. A flush only acts once the FIFO is
  // empty, so pending data is always packed before a partial word goes out.
  always_comb begin
    w_state_nxt  = r_state;
    w_pop        = 1'b0;
    w_flush_emit = 1'b0;
    w_flush_drop = 1'b0;
    w_release    = 1'b0;
    case (r_state)
      FILL: begin
        w_pop = reset_n && !fifo_empty && (r_lane_cnt < c_NB_CNT);
        if (w_pop) begin
          if (r_lane_cnt == c_LAST_LANE) begin
            w_state_nxt = HOLD;
          end
        end else if (r_flush_pend && fifo_empty) begin
          if (r_lane_cnt != '0) begin
            w_flush_emit = 1'b1;
            w_state_nxt  = HOLD;
          end else begin
            w_flush_drop = 1'b1;
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          w_release   = 1'b1;
          w_state_nxt = FILL;
        end
      end
      default: begin
        w_state_nxt = FILL;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state      <= FILL;
      r_lane_cnt   <= '0;
      r_data       <= '0;
      r_be         <= '0;
      r_last       <= 1'b0;
      r_flush_pend <= 1'b0;
    end else begin
      r_state <= w_state_nxt;

      // Consuming the pending flush wins; a second flush while one is
      // already pending (including the cycle it is consumed) is absorbed.
      if (w_flush_emit || w_flush_drop) begin
        r_flush_pend <= 1'b0;
      end else if (flush) begin
        r_flush_pend <= 1'b1;
      end

      if (w_release) begin
        // Clearing data here keeps unfilled lanes of a later partial word zero.
        r_lane_cnt <= '0;
        r_data     <= '0;
        r_be       <= '0;
        r_last     <= 1'b0;
      end else if (w_pop) begin
        for (int i = 0; i < NB; i++) begin
          if (r_lane_cnt == (IW+1)'(i)) begin
            r_data[i*WD +: WD] <= fifo_rd_data;
            r_be[i]            <= 1'b1;
          end
        end
        r_lane_cnt <= r_lane_cnt + c_ONE;
      end

      if (w_flush_emit) begin
        r_last <= 1'b1;
      end
    end
  end

  assign fifo_rd_en = w_pop;
  assign out_valid  = (r_state == HOLD);
  assign out_data   = r_data;
  assign out_be     = r_be;
  assign out_last   = r_last;
  assign lane_cnt   = r_lane_cnt;

endmodule
`default_nettype wire

// File: tb/tb_fifo_word_packer.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_word_packer
// Description : Self-checking bench for fifo_word_packer. Models the upstream
//               show-ahead FIFO with a byte queue; expected words (directed
//               tests) or expected bytes (random stream) are queued when the
//               stimulus is driven and compared when the DUT hands a word off.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_word_packer;

  localparam int WD = 8;
  localparam int NB = 4;
  localparam int IW = 2;

  typedef struct packed {
    logic [NB*WD-1:0] data;
    logic [NB-1:0]    be;
    logic             last;
  } word_t;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             fifo_empty;
  logic [WD-1:0]    fifo_rd_data;
  logic             fifo_rd_en;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [NB*WD-1:0] out_data;
  logic [NB-1:0]    out_be;
  logic             out_last;
  logic [IW:0]      lane_cnt;

  always #5 clk = ~clk;

  fifo_word_packer #(.WD(WD), .NB(NB), .IW(IW)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .fifo_empty   (fifo_empty),
    .fifo_rd_data (fifo_rd_data),
    .fifo_rd_en   (fifo_rd_en),
    .flush        (flush),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_be       (out_be),
    .out_last     (out_last),
    .lane_cnt     (lane_cnt)
  );

  word_t          exp_words[$];
  logic [WD-1:0]  exp_bytes[$];
  logic [WD-1:0]  fifo_q[$];

  int  n_tests   = 0;
  int  n_fail    = 0;
  int  rd_cnt    = 0;
  int  word_cnt  = 0;
  bit  stream_mode = 1'b0;
  bit  gate        = 1'b0;

  logic             prev_stall = 1'b0;
  logic [NB*WD-1:0] prev_data;
  logic [NB-1:0]    prev_be;
  logic             prev_last;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive_fifo();
    fifo_empty   = gate || (fifo_q.size() == 0);
    fifo_rd_data = (fifo_q.size() > 0) ? fifo_q[0] : '0;
  endtask

  task automatic push_byte(input logic [WD-1:0] b);
    fifo_q.push_back(b);
    if (stream_mode) exp_bytes.push_back(b);
    drive_fifo();
  endtask

  task automatic expect_word(input logic [NB*WD-1:0] d, input logic [NB-1:0] be, input logic last);
    word_t w;
    w.data = d;
    w.be   = be;
    w.last = last;
    exp_words.push_back(w);
  endtask

  // One clock: sample on the falling edge, apply the FIFO pop and the output
  // handshake that took effect at the rising edge, then re-drive inputs.
  task automatic tick();
    logic             s_rd, s_empty, s_v, s_rdy, s_last, s_rst;
    logic [NB*WD-1:0] s_data;
    logic [NB-1:0]    s_be;
    logic [WD-1:0]    dummy;
    word_t            w;
    @(negedge clk);
    s_rd    = fifo_rd_en;
    s_empty = fifo_empty;
    s_v     = out_valid;
    s_rdy   = out_ready;
    s_data  = out_data;
    s_be    = out_be;
    s_last  = out_last;
    s_rst   = reset_n;
    check("no_underflow", 64'(s_rd & s_empty), 64'(0));
    check("no_pop_in_hold", 64'(s_rd & s_v), 64'(0));
    if (prev_stall)
      check("hold_stable", 64'({s_v, s_last, s_be, s_data}),
                           64'({1'b1, prev_last, prev_be, prev_data}));
    prev_stall = s_v && !s_rdy && s_rst;
    prev_data  = s_data;
    prev_be    = s_be;
    prev_last  = s_last;
    @(posedge clk);
    #1;
    if (s_rd && fifo_q.size() > 0) begin
      dummy = fifo_q.pop_front();
      rd_cnt++;
    end
    if (s_v && s_rdy && s_rst) begin
      word_cnt++;
      if (stream_mode) begin
        for (int i = 0; i < NB; i++) begin
          if (s_be[i]) begin
            if (exp_bytes.size() == 0) check("extra_byte", 64'(1), 64'(0));
            else begin
              dummy = exp_bytes.pop_front();
              check("stream_byte", 64'(s_data[i*WD +: WD]), 64'(dummy));
            end
          end
        end
      end else if (exp_words.size() == 0) begin
        check("unexpected_word", 64'(s_data), 64'(0) - 64'(1));
      end else begin
        w = exp_words.pop_front();
        check("word_data", 64'(s_data), 64'(w.data));
        check("word_be",   64'(s_be),   64'(w.be));
        check("word_last", 64'(s_last), 64'(w.last));
      end
    end
    flush = 1'b0;
    drive_fifo();
  endtask

  task automatic drain(input string tag, input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      if (((stream_mode && exp_bytes.size() == 0) || (!stream_mode && exp_words.size() == 0))
          && fifo_q.size() == 0 && !out_valid)
        break;
      tick();
    end
    check(tag, 64'(i < budget), 64'(1));
  endtask

  initial begin
    int r0;
    int w0;
    int k;

    // Reset: outputs cleared and no pops even with data waiting.
    reset_n   = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    gate      = 1'b0;
    drive_fifo();
    push_byte(8'h5A);
    tick();
    tick();
    check("rst_rd_en",     64'(fifo_rd_en), 64'(0));
    check("rst_out_valid", 64'(out_valid),  64'(0));
    check("rst_lane_cnt",  64'(lane_cnt),   64'(0));
    check("rst_out_be",    64'(out_be),     64'(0));
    check("rst_out_data",  64'(out_data),   64'(0));
    check("rst_out_last",  64'(out_last),   64'(0));
    fifo_q.delete();
    drive_fifo();
    reset_n = 1'b1;
    tick();

    // Full word, four pops.
    r0 = rd_cnt;
    push_byte(8'h11); push_byte(8'h22); push_byte(8'h33); push_byte(8'h44);
    expect_word(32'h4433_2211, 4'hF, 1'b0);
    drain("t1_drain", 50);
    check("t1_rd_en_pulses", 64'(rd_cnt - r0), 64'(4));

    // Partial word via flush after the FIFO empties.
    push_byte(8'hAA); push_byte(8'hBB);
    expect_word(32'h0000_BBAA, 4'h3, 1'b1);
    repeat (6) tick();
    check("t2_lane_cnt", 64'(lane_cnt),  64'(2));
    check("t2_no_valid", 64'(out_valid), 64'(0));
    flush = 1'b1;
    tick();
    drain("t2_drain", 20);

    // Flush with nothing collected: no word, and the request does not linger.
    w0 = word_cnt;
    flush = 1'b1;
    tick();
    repeat (5) tick();
    check("t3_no_word",  64'(word_cnt - w0), 64'(0));
    check("t3_lane_cnt", 64'(lane_cnt),      64'(0));
    push_byte(8'hC3);
    repeat (6) tick();
    check("t3_pend_cleared", 64'(word_cnt - w0), 64'(0));
    check("t3_lane_one",     64'(lane_cnt),      64'(1));
    expect_word(32'h0000_00C3, 4'h1, 1'b1);
    flush = 1'b1;
    tick();
    drain("t3_drain", 20);

    // Stalled output: first word held, no pops, then second word.
    out_ready = 1'b0;
    for (int b = 1; b <= 8; b++) push_byte(8'(b));
    expect_word(32'h0403_0201, 4'hF, 1'b0);
    expect_word(32'h0807_0605, 4'hF, 1'b0);
    repeat (10) tick();
    check("t4_valid", 64'(out_valid),  64'(1));
    check("t4_data",  64'(out_data),   64'(32'h0403_0201));
    check("t4_be",    64'(out_be),     64'(4'hF));
    check("t4_rd_en", 64'(fifo_rd_en), 64'(0));
    out_ready = 1'b1;
    drain("t4_drain", 50);

    // Flush arriving during HOLD is served after the held word.
    out_ready = 1'b0;
    push_byte(8'hE1); push_byte(8'hE2); push_byte(8'hE3); push_byte(8'hE4); push_byte(8'hE5);
    expect_word(32'hE4E3_E2E1, 4'hF, 1'b0);
    expect_word(32'h0000_00E5, 4'h1, 1'b1);
    k = 0;
    while (!out_valid && k < 20) begin tick(); k++; end
    check("t5_hold_reached", 64'(out_valid), 64'(1));
    flush = 1'b1;
    tick();
    repeat (3) tick();
    out_ready = 1'b1;
    drain("t5_drain", 30);

    // Reset mid-word discards the partial bytes.
    r0 = rd_cnt;
    push_byte(8'h99); push_byte(8'h9A); push_byte(8'h9B);
    k = 0;
    while ((rd_cnt - r0) < 3 && k < 20) begin tick(); k++; end
    check("t6_three_pops", 64'(rd_cnt - r0), 64'(3));
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    check("t6_lane_cleared", 64'(lane_cnt), 64'(0));
    push_byte(8'h55); push_byte(8'h66); push_byte(8'h77); push_byte(8'h88);
    expect_word(32'h8877_6655, 4'hF, 1'b0);
    drain("t6_drain", 50);

    // Random FIFO availability, backpressure and flushes; byte stream preserved.
    stream_mode = 1'b1;
    for (int c = 0; c < 10000; c++) begin
      gate      = ($urandom_range(0, 3) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 63) == 0);
      if (fifo_q.size() < 8 && $urandom_range(0, 1) == 1)
        push_byte(8'($urandom_range(0, 255)));
      drive_fifo();
      tick();
    end
    gate      = 1'b0;
    out_ready = 1'b1;
    drive_fifo();
    k = 0;
    while (fifo_q.size() > 0 && k < 100) begin tick(); k++; end
    check("rand_fifo_emptied", 64'(fifo_q.size()), 64'(0));
    repeat (2) tick();
    flush = 1'b1;
    tick();
    drain("rand_drain", 50);
    check("rand_all_bytes_out", 64'(exp_bytes.size()), 64'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
